// File: rtl/adam_pause_seq.sv
// Ordered pause/reset distributor: pauses downstream units in ascending index order,
// resumes them in descending order with a per-step timeout, and stretches the group reset.
module adam_pause_seq #(
  parameter int unsigned NO_CHANS   = 4,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned RST_CYCLES = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_rst_in,
  input  logic                i_pause_req,
  output logic                o_pause_ack,
  input  logic [NO_CHANS-1:0] i_chan_mask,
  output logic [NO_CHANS-1:0] o_chan_rst,
  output logic [NO_CHANS-1:0] o_chan_pause_req,
  input  logic [NO_CHANS-1:0] i_chan_pause_ack,
  output logic [NO_CHANS-1:0] o_err,
  input  logic                i_err_clr
);

  localparam int unsigned IW = (NO_CHANS > 1) ? $clog2(NO_CHANS) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam int unsigned RW = $clog2(RST_CYCLES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NO_CHANS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RST_LOAD = RW'(RST_CYCLES);

  typedef enum logic [1:0] {RUN, PAUSING, PAUSED, RESUMING} state_e;

  state_e              r_state, w_state_nxt;
  logic [IW-1:0]       r_idx, w_idx_nxt;
  logic [CW-1:0]       r_cnt;
  logic                r_skip;
  logic                w_entry, w_dir;
  logic [NO_CHANS-1:0] r_req, w_req_nxt;
  logic [NO_CHANS-1:0] r_err, w_err_set;
  logic [NO_CHANS-1:0] r_chan_rst;
  logic                r_ack, w_ack_nxt;
  logic [RW-1:0]       r_rst_cnt;
  logic                w_ack_ok, w_timeout, w_done, w_rst_hold;

  // A step completes on the expected ack level, a channel masked at entry, or timeout.
  always_comb begin
    w_ack_ok  = (i_chan_pause_ack[r_idx] == (r_state == PAUSING));
    w_timeout = (r_cnt == CNT_LAST);
    w_done    = r_skip | w_ack_ok | w_timeout;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= PAUSED;
      r_idx   <= LAST_IDX;
      r_cnt   <= '0;
      r_skip  <= 1'b0;
      r_req   <= ~i_chan_mask;
      r_ack   <= 1'b1;
      r_err   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= (w_entry || w_state_nxt == RUN || w_state_nxt == PAUSED) ? '0 : r_cnt + 1'b1;
      if (w_entry) r_skip <= i_chan_mask[w_idx_nxt];
      r_req   <= w_req_nxt;
      r_ack   <= w_ack_nxt;
      r_err   <= (r_err & ~{NO_CHANS{i_err_clr}}) | w_err_set;
    end
  end

  // A reversal re-enters the current idx in the new direction rather than skipping it.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_entry     = 1'b0;
    w_dir       = 1'b0;
    unique case (r_state)
      RUN: begin
        if (i_pause_req) begin
          w_state_nxt = PAUSING;
          w_idx_nxt   = '0;
          w_entry     = 1'b1;
          w_dir       = 1'b1;
        end
      end
      PAUSED: begin
        if (!i_pause_req) begin
          w_state_nxt = RESUMING;
          w_idx_nxt   = LAST_IDX;
          w_entry     = 1'b1;
        end
      end
      PAUSING: begin
        if (w_done) begin
          if (!i_pause_req) begin
            w_state_nxt = RESUMING;
            w_entry     = 1'b1;
          end else if (r_idx == LAST_IDX) begin
            w_state_nxt = PAUSED;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
            w_entry   = 1'b1;
            w_dir     = 1'b1;
          end
        end
      end
      RESUMING: begin
        if (w_done) begin
          if (i_pause_req) begin
            w_state_nxt = PAUSING;
            w_entry     = 1'b1;
            w_dir       = 1'b1;
          end else if (r_idx == '0) begin
            w_state_nxt = RUN;
          end else begin
            w_idx_nxt = r_idx - 1'b1;
            w_entry   = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    w_req_nxt = r_req;
    if (w_entry) w_req_nxt[w_idx_nxt] = w_dir & ~i_chan_mask[w_idx_nxt];
    w_ack_nxt = r_ack;
    if (w_state_nxt == PAUSED)   w_ack_nxt = 1'b1;
    else if (w_state_nxt == RUN) w_ack_nxt = 1'b0;
    w_err_set = '0;
    if ((r_state == PAUSING || r_state == RESUMING) && !r_skip && !w_ack_ok && w_timeout)
      w_err_set[r_idx] = 1'b1;
  end

  // Reset stretcher runs independently of the pause FSM.
  assign w_rst_hold = i_rst_in | (r_rst_cnt != '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rst_cnt  <= RST_LOAD;
      r_chan_rst <= '1;
    end else begin
      if (i_rst_in)               r_rst_cnt <= RST_LOAD;
      else if (r_rst_cnt != '0)   r_rst_cnt <= r_rst_cnt - 1'b1;
      r_chan_rst <= {NO_CHANS{w_rst_hold}} & ~i_chan_mask;
    end
  end

  assign o_pause_ack      = r_ack;
  assign o_chan_pause_req = r_req;
  assign o_err            = r_err;
  assign o_chan_rst       = r_chan_rst;

endmodule

// File: tb/tb_adam_pause_seq.sv
// Directed bench for adam_pause_seq (4 channels, TIMEOUT=16, RST_CYCLES=8) with a
// 1-cycle ack mirror per channel and hand-computed per-cycle expectations.
module tb_adam_pause_seq;

  logic       clk = 1'b0;
  logic       rst, rst_in, pause_req, err_clr, pause_ack;
  logic [3:0] mask, chan_rst, req, ack, err, ack_m, tie;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] q_req[$];
  logic [3:0] q_rst[$];
  logic       q_ack[$];

  always #5 clk = ~clk;

  // Units ack one cycle after their request; tie forces selected acks low.
  always @(posedge clk) ack_m <= req;
  assign ack = ack_m & ~tie;

  adam_pause_seq #(
    .NO_CHANS  (4),
    .TIMEOUT   (16),
    .RST_CYCLES(8)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_rst_in        (rst_in),
    .i_pause_req     (pause_req),
    .o_pause_ack     (pause_ack),
    .i_chan_mask     (mask),
    .o_chan_rst      (chan_rst),
    .o_chan_pause_req(req),
    .i_chan_pause_ack(ack),
    .o_err           (err),
    .i_err_clr       (err_clr)
  );

  task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < q_req.size(); i++) begin
      tick(1);
      check_val($sformatf("%s_req%0d", tag, i), req, q_req[i]);
      check_val($sformatf("%s_ack%0d", tag, i), {3'b000, pause_ack}, {3'b000, q_ack[i]});
      check_val($sformatf("%s_rst%0d", tag, i), chan_rst, q_rst[i]);
    end
  endtask

  task automatic resume_all_table(input string tag);
    q_req = '{4'h7, 4'h7, 4'h3, 4'h3, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
    q_ack = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    q_rst = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    run_table(tag);
  endtask

  initial begin
    rst = 1'b1; rst_in = 1'b0; pause_req = 1'b0; err_clr = 1'b0;
    mask = 4'h0; tie = 4'h0;
    tick(2);
    check_val("rst_chan_rst", chan_rst, 4'hF);
    check_val("rst_req", req, 4'hF);
    check_val("rst_pause_ack", {3'b000, pause_ack}, 4'h1);
    check_val("rst_err", err, 4'h0);
    rst = 1'b0;

    // Release from reset with pause_req low: descending resume, stretch ends too.
    q_req = '{4'h7, 4'h7, 4'h3, 4'h3, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
    q_ack = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    q_rst = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0};
    run_table("rsm0");
    check_val("rsm0_err", err, 4'h0);

    // Ascending pause from RUN; pause_ack rises 9 cycles after the sample.
    pause_req = 1'b1;
    q_req = '{4'h1, 4'h1, 4'h3, 4'h3, 4'h7, 4'h7, 4'hF, 4'hF, 4'hF};
    q_ack = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    q_rst = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    run_table("pause");

    pause_req = 1'b0;
    resume_all_table("rsm1");

    // Channel 2 never acks: 16-cycle timeout step, err[2] set, sequence continues.
    tie = 4'b0100;
    pause_req = 1'b1;
    tick(1);  check_val("to_req_s0", req, 4'h1);
    tick(4);  check_val("to_req_s2_entry", req, 4'h7);
    tick(15); check_val("to_req_s2_last", req, 4'h7);
              check_val("to_err_before", err, 4'h0);
    tick(1);  check_val("to_req_s3", req, 4'hF);
              check_val("to_err_set", err, 4'h4);
    tick(1);  check_val("to_ack_low", {3'b000, pause_ack}, 4'h0);
    tick(1);  check_val("to_ack_high", {3'b000, pause_ack}, 4'h1);
    err_clr = 1'b1;
    tie = 4'h0;
    tick(1);  check_val("err_clr", err, 4'h0);
    err_clr = 1'b0;
    pause_req = 1'b0;
    resume_all_table("rsm2");

    // Channel 1 masked: 1-cycle step, never requested, reset forced low.
    mask = 4'b0010;
    rst_in = 1'b1;
    tick(1);
    check_val("mask_rst_pulse", chan_rst, 4'hD);
    rst_in = 1'b0;
    pause_req = 1'b1;
    q_req = '{4'h1, 4'h1, 4'h1, 4'h5, 4'h5, 4'hD, 4'hD, 4'hD};
    q_ack = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    q_rst = '{4'hD, 4'hD, 4'hD, 4'hD, 4'hD, 4'hD, 4'hD, 4'hD};
    run_table("mpause");
    pause_req = 1'b0;
    q_req = '{4'h5, 4'h5, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
    q_ack = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    q_rst = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    run_table("mrsm");
    mask = 4'h0;

    // Drop pause_req while step 1 waits: step 1 finishes, then 1 and 0 release.
    pause_req = 1'b1;
    q_req = '{4'h1, 4'h1, 4'h3};
    q_ack = '{1'b0, 1'b0, 1'b0};
    q_rst = '{4'h0, 4'h0, 4'h0};
    run_table("revA");
    pause_req = 1'b0;
    q_req = '{4'h3, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0};
    q_ack = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    q_rst = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    run_table("revB");

    // 3-cycle rst_in pulse, re-asserted 4 cycles into the stretch.
    for (int k = 1; k <= 17; k++) begin
      rst_in = (k <= 3) || (k == 8);
      tick(1);
      check_val($sformatf("stretch%0d", k), chan_rst, (k < 17) ? 4'hF : 4'h0);
    end
    rst_in = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
